// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite blocks: the master FSM state encoding,
// the response codes and the default protection value driven on AWPROT/ARPROT.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr,       // AW and W outstanding
        StWrResp,   // waiting for B
        StRdAddr,   // AR outstanding
        StRdData,   // waiting for R
        StRsp       // response held for the local consumer
    } axi_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/dff_async_rst_n.sv
// Enabled D flip-flop bank with asynchronous active-low reset to zero.
// Ports:
//   i_clock     clock
//   i_areset_n  asynchronous active-low reset, clears o_q
//   i_en        load enable
//   i_d         next value, loaded when i_en is high
//   o_q         registered value
module dff_async_rst_n #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clock,
    input  logic             i_areset_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge i_clock or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/axi4_lite_master.sv
// AXI4-Lite manager: converts a single-outstanding command/response interface
// into AXI4-Lite read and write transactions. One transaction in flight at a time.
// Ports:
//   i_clock, i_areset_n            clock, asynchronous active-low reset
//   i_cmd_* / o_cmd_ready          command request (write flag, addr, wdata, wstrb)
//   o_rsp_* / i_rsp_ready          response (write flag, rdata, resp), held until accepted
//   o_aw*, o_w*, o_bready, i_b*    AXI4-Lite write address, write data, write response
//   o_ar*, o_rready, i_r*          AXI4-Lite read address, read data
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,   // 32 or 64
    parameter logic [2:0]  PROT       = PROT_DEFAULT,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_clock,
    input  logic                  i_areset_n,
    // command
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    input  logic [STRB_WIDTH-1:0] i_cmd_wstrb,
    // response
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic                  o_rsp_write,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]            o_rsp_resp,
    // write address
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic [2:0]            o_awprot,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    // write data
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [STRB_WIDTH-1:0] o_wstrb,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    // write response
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    // read address
    output logic [ADDR_WIDTH-1:0] o_araddr,
    output logic [2:0]            o_arprot,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    // read data
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_rresp,
    input  logic                  i_rvalid,
    output logic                  o_rready
);

    axi_state_e state;
    logic       aw_done;
    logic       w_done;

    logic cmd_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic r_hs;

    logic [2:0] prot_q;

    logic                  rsp_en;
    logic                  rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic [1:0]            rsp_resp_d;

    // Reads 1 during reset since the state register resets to StIdle.
    assign o_cmd_ready = (state == StIdle);

    assign cmd_hs = i_cmd_valid & o_cmd_ready;
    assign aw_hs  = o_awvalid & i_awready;
    assign w_hs   = o_wvalid & i_wready;
    // bready/rready are only high in their waiting states, so stray B/R beats are dropped.
    assign b_hs   = i_bvalid & o_bready;
    assign r_hs   = i_rvalid & o_rready;

    // ---------------------------------------------------------------- payload
    // AW/W and AR payloads load separately so each channel keeps its last value.
    dff_async_rst_n #(.WIDTH(ADDR_WIDTH)) u_awaddr (
        .i_clock    (i_clock),
        .i_areset_n (i_areset_n),
        .i_en       (cmd_hs & i_cmd_write),
        .i_d        (i_cmd_addr),
        .o_q        (o_awaddr)
    );

    dff_async_rst_n #(.WIDTH(DATA_WIDTH)) u_wdata (
        .i_clock    (i_clock),
        .i_areset_n (i_areset_n),
        .i_en       (cmd_hs & i_cmd_write),
        .i_d        (i_cmd_wdata),
        .o_q        (o_wdata)
    );

    dff_async_rst_n #(.WIDTH(STRB_WIDTH)) u_wstrb (
        .i_clock    (i_clock),
        .i_areset_n (i_areset_n),
        .i_en       (cmd_hs & i_cmd_write),
        .i_d        (i_cmd_wstrb),
        .o_q        (o_wstrb)
    );

    dff_async_rst_n #(.WIDTH(ADDR_WIDTH)) u_araddr (
        .i_clock    (i_clock),
        .i_areset_n (i_areset_n),
        .i_en       (cmd_hs & ~i_cmd_write),
        .i_d        (i_cmd_addr),
        .o_q        (o_araddr)
    );

    // Registered so PROT reads 0 while reset is asserted.
    dff_async_rst_n #(.WIDTH(3)) u_prot (
        .i_clock    (i_clock),
        .i_areset_n (i_areset_n),
        .i_en       (1'b1),
        .i_d        (PROT),
        .o_q        (prot_q)
    );

    assign o_awprot = prot_q;
    assign o_arprot = prot_q;

    // --------------------------------------------------------------- response
    always_comb begin
        rsp_write_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_resp_d  = i_bresp;
        if (r_hs) begin
            rsp_write_d = 1'b0;
            rsp_rdata_d = i_rdata;
            rsp_resp_d  = i_rresp;
        end
    end

    assign rsp_en = b_hs | r_hs;

    dff_async_rst_n #(.WIDTH(1)) u_rsp_write (
        .i_clock    (i_clock),
        .i_areset_n (i_areset_n),
        .i_en       (rsp_en),
        .i_d        (rsp_write_d),
        .o_q        (o_rsp_write)
    );

    dff_async_rst_n #(.WIDTH(DATA_WIDTH)) u_rsp_rdata (
        .i_clock    (i_clock),
        .i_areset_n (i_areset_n),
        .i_en       (rsp_en),
        .i_d        (rsp_rdata_d),
        .o_q        (o_rsp_rdata)
    );

    dff_async_rst_n #(.WIDTH(2)) u_rsp_resp (
        .i_clock    (i_clock),
        .i_areset_n (i_areset_n),
        .i_en       (rsp_en),
        .i_d        (rsp_resp_d),
        .o_q        (o_rsp_resp)
    );

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge i_clock or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state       <= StIdle;
            o_awvalid   <= 1'b0;
            o_wvalid    <= 1'b0;
            o_bready    <= 1'b0;
            o_arvalid   <= 1'b0;
            o_rready    <= 1'b0;
            o_rsp_valid <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        if (i_cmd_write) begin
                            state     <= StWr;
                            o_awvalid <= 1'b1;
                            o_wvalid  <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                        end else begin
                            state     <= StRdAddr;
                            o_arvalid <= 1'b1;
                        end
                    end
                end
                StWr: begin
                    if (aw_hs) begin
                        o_awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        o_wvalid <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    // AW and W may finish in either order or together.
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        state    <= StWrResp;
                        o_bready <= 1'b1;
                    end
                end
                StWrResp: begin
                    if (i_bvalid) begin
                        state       <= StRsp;
                        o_bready    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                    end
                end
                StRdAddr: begin
                    if (i_arready) begin
                        state     <= StRdData;
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                    end
                end
                StRdData: begin
                    if (i_rvalid) begin
                        state       <= StRsp;
                        o_rready    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                    end
                end
                StRsp: begin
                    if (i_rsp_ready) begin
                        state       <= StIdle;
                        o_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // command / response side
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_ready;
    logic        rsp_valid, rsp_write;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    // AXI side
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    axi4_lite_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .PROT       (3'b000)
    ) dut (
        .i_clock     (clk),
        .i_areset_n  (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_write (cmd_write),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_wdata (cmd_wdata),
        .i_cmd_wstrb (cmd_wstrb),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_write (rsp_write),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_resp  (rsp_resp),
        .o_awaddr    (awaddr),
        .o_awprot    (awprot),
        .o_awvalid   (awvalid),
        .i_awready   (awready),
        .o_wdata     (wdata),
        .o_wstrb     (wstrb),
        .o_wvalid    (wvalid),
        .i_wready    (wready),
        .i_bresp     (bresp),
        .i_bvalid    (bvalid),
        .o_bready    (bready),
        .o_araddr    (araddr),
        .o_arprot    (arprot),
        .o_arvalid   (arvalid),
        .i_arready   (arready),
        .i_rdata     (rdata),
        .i_rresp     (rresp),
        .i_rvalid    (rvalid),
        .o_rready    (rready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // ------------------------------------------------------------ slave model
    // All slave decisions are made on the falling edge; a ready/valid decided
    // here is the value seen at the next rising edge.
    int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
    logic [1:0]  cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;
    logic [31:0] smem [256];
    logic        aw_have = 0, w_have = 0, ar_have = 0, b_fire = 0, r_fire = 0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    logic [2:0]  cap_awprot = '0, cap_arprot = '0;
    logic        pv_aw = 0, pr_aw = 0, pv_w = 0, pr_w = 0, pv_ar = 0, pr_ar = 0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
    logic [3:0]  p_wstrb = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_have = 0; w_have = 0; ar_have = 0; b_fire = 0; r_fire = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
            pv_aw = 0; pr_aw = 0; pv_w = 0; pr_w = 0; pv_ar = 0; pr_ar = 0;
        end else begin
            // A VALID must persist with a stable payload until its handshake.
            if (pv_aw && !pr_aw) check("awvalid/awaddr held", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (pv_w && !pr_w) check("wvalid/wdata held", {wvalid, wstrb, wdata}, {1'b1, p_wstrb, p_wdata});
            if (pv_ar && !pr_ar) check("arvalid/araddr held", {arvalid, araddr}, {1'b1, p_araddr});
            // B before AW/W so a fresh AW/W capture is seen one edge later.
            if (b_fire) begin bvalid = 0; b_fire = 0; end
            if (!bvalid && aw_have && w_have) begin
                if (b_wait >= cfg_b_dly) begin
                    if (cfg_bresp == RESP_OKAY)
                        smem[cap_awaddr[9:2]] = merge(smem[cap_awaddr[9:2]], cap_wdata, cap_wstrb);
                    bvalid = 1; bresp = cfg_bresp; aw_have = 0; w_have = 0; b_wait = 0;
                end else b_wait++;
            end
            if (bvalid && bready) b_fire = 1;
            if (r_fire) begin rvalid = 0; r_fire = 0; end
            if (!rvalid && ar_have) begin
                if (r_wait >= cfg_r_dly) begin
                    rvalid = 1; rdata = smem[cap_araddr[9:2]]; rresp = cfg_rresp;
                    ar_have = 0; r_wait = 0;
                end else r_wait++;
            end
            if (rvalid && rready) r_fire = 1;
            awready = 0;
            if (awvalid && !aw_have) begin
                if (aw_wait >= cfg_aw_dly) begin
                    awready = 1; aw_have = 1; cap_awaddr = awaddr; cap_awprot = awprot; aw_wait = 0;
                end else aw_wait++;
            end
            wready = 0;
            if (wvalid && !w_have) begin
                if (w_wait >= cfg_w_dly) begin
                    wready = 1; w_have = 1; cap_wdata = wdata; cap_wstrb = wstrb; w_wait = 0;
                end else w_wait++;
            end
            arready = 0;
            if (arvalid && !ar_have) begin
                if (ar_wait >= cfg_ar_dly) begin
                    arready = 1; ar_have = 1; cap_araddr = araddr; cap_arprot = arprot; ar_wait = 0;
                end else ar_wait++;
            end
            pv_aw = awvalid; pr_aw = awready; p_awaddr = awaddr;
            pv_w = wvalid; pr_w = wready; p_wdata = wdata; p_wstrb = wstrb;
            pv_ar = arvalid; pr_ar = arready; p_araddr = araddr;
        end
    end

    // ---------------------------------------------------------------- driver
    // Called on a falling edge; returns one falling edge after acceptance.
    task automatic accept_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output int t_acc, output int waits);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        waits = 0;
        while (!cmd_ready && waits < 200) begin @(negedge clk); waits++; end
        check("cmd accepted", cmd_ready, 1);
        t_acc = cyc;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic finish_rsp(input string name, input logic exp_wr, input logic [31:0] exp_rd,
                              input logic [1:0] exp_resp, input int bp, input int t_acc,
                              input int exp_lat);
        int n;
        logic [34:0] keep;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        check({name, " rsp_valid"}, rsp_valid, 1);
        if (exp_lat > 0) check({name, " latency"}, cyc - t_acc, exp_lat);
        check({name, " rsp_write"}, rsp_write, exp_wr);
        check({name, " rsp_rdata"}, rsp_rdata, exp_rd);
        check({name, " rsp_resp"}, rsp_resp, exp_resp);
        keep = {rsp_write, rsp_rdata, rsp_resp};
        for (int i = 1; i < bp; i++) begin
            @(negedge clk);
            check({name, " rsp held"}, {rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp},
                  {1'b1, 1'b0, keep});
        end
        rsp_ready = 1;
        @(negedge clk);
        check({name, " back to idle"}, {cmd_ready, rsp_valid}, 2'b10);
    endtask

    task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
        cfg_aw_dly = aw; cfg_w_dly = w; cfg_b_dly = b; cfg_ar_dly = ar; cfg_r_dly = r;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  resp;
        int          bp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] ref_mem [256];
        int t_acc, waits, t2, wr_rsps, lat, idx;
        logic wr;
        logic [31:0] addr, data, exp_rd;
        logic [3:0] strb;
        logic [1:0] resp;
        int bp, d_aw, d_w, d_b, d_ar, d_r;

        for (int i = 0; i < 256; i++) begin smem[i] = '0; ref_mem[i] = '0; end

        //            wr addr    wdata         strb aw w b ar r resp        bp exp_rd        exp_resp   lat
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, RESP_OKAY,   0, 32'h0,        RESP_OKAY,   3};
        vecs[1] = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, RESP_OKAY,   0, 32'hDEADBEEF, RESP_OKAY,   3};
        vecs[2] = '{1'b1, 32'h10, 32'hAABBCCDD, 4'h5, 0, 0, 0, 0, 0, RESP_OKAY,   0, 32'h0,        RESP_OKAY,   3};
        vecs[3] = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 1, RESP_OKAY,   5, 32'hDEBBBEDD, RESP_OKAY,   4};
        vecs[4] = '{1'b1, 32'h20, 32'h12345678, 4'hF, 0, 2, 1, 0, 0, RESP_OKAY,   0, 32'h0,        RESP_OKAY,   6};
        vecs[5] = '{1'b0, 32'h20, 32'h0,        4'h0, 0, 0, 0, 0, 2, RESP_SLVERR, 0, 32'h12345678, RESP_SLVERR, 5};
        vecs[6] = '{1'b1, 32'h30, 32'h11111111, 4'hF, 1, 1, 0, 0, 0, RESP_DECERR, 2, 32'h0,        RESP_DECERR, 4};
        vecs[7] = '{1'b0, 32'h30, 32'h0,        4'h0, 0, 0, 0, 3, 0, RESP_OKAY,   0, 32'h0,        RESP_OKAY,   6};

        // reset state
        repeat (3) @(negedge clk);
        check("rst valids/readies", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
        check("rst addresses", {awaddr, araddr}, 64'h0);
        check("rst data", {wdata, rsp_rdata}, 64'h0);
        check("rst misc", {wstrb, awprot, arprot, rsp_write, rsp_resp}, 13'h0);
        check("rst cmd_ready", cmd_ready, 1);
        rst_n = 1;
        @(negedge clk);
        check("post-rst idle", {cmd_ready, rsp_valid}, 2'b10);

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            set_dly(vecs[i].aw_d, vecs[i].w_d, vecs[i].b_d, vecs[i].ar_d, vecs[i].r_d);
            cfg_bresp = vecs[i].resp; cfg_rresp = vecs[i].resp;
            rsp_ready = (vecs[i].bp == 0);
            accept_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, t_acc, waits);
            check($sformatf("vec%0d accept wait", i), waits, 0);
            finish_rsp($sformatf("vec%0d", i), vecs[i].wr, vecs[i].exp_rdata, vecs[i].exp_resp,
                       vecs[i].bp, t_acc, vecs[i].exp_lat);
            if (vecs[i].wr)
                check($sformatf("vec%0d aw/w payload", i), {cap_awprot, cap_wstrb, cap_awaddr, cap_wdata},
                      {3'b000, vecs[i].strb, vecs[i].addr, vecs[i].wdata});
            else
                check($sformatf("vec%0d ar payload", i), {cap_arprot, cap_araddr}, {3'b000, vecs[i].addr});
        end

        // skewed write: AW stalled 3 cycles, W immediate
        set_dly(3, 0, 0, 0, 0); cfg_bresp = RESP_OKAY; rsp_ready = 1;
        accept_cmd(1'b1, 32'h0C, 32'h0BADF00D, 4'hF, t_acc, waits);
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) @(negedge clk);
            check($sformatf("skew c%0d aw/w/b", i), {awvalid, wvalid, bready},
                  {(i <= 4) ? 1'b1 : 1'b0, (i == 1) ? 1'b1 : 1'b0, (i == 5) ? 1'b1 : 1'b0});
            if (i <= 4) check($sformatf("skew c%0d awaddr", i), awaddr, 32'h0C);
        end
        finish_rsp("skew", 1'b1, 32'h0, RESP_OKAY, 0, t_acc, 6);

        // back-to-back: write then read with cmd_valid held high
        set_dly(0, 0, 0, 0, 0); rsp_ready = 1; wr_rsps = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h04; cmd_wdata = 32'h5A5A1234; cmd_wstrb = 4'hF;
        waits = 0;
        while (!cmd_ready && waits < 50) begin @(negedge clk); waits++; end
        t_acc = cyc;
        @(negedge clk);
        cmd_write = 0; cmd_wdata = '0; cmd_wstrb = '0;
        waits = 0;
        while (!cmd_ready && waits < 50) begin
            if (rsp_valid) begin
                wr_rsps++;
                check("b2b write rsp", {rsp_write, rsp_rdata, rsp_resp}, {1'b1, 32'h0, RESP_OKAY});
            end
            @(negedge clk);
            waits++;
        end
        check("b2b write rsp count", wr_rsps, 1);
        check("b2b issue interval", cyc - t_acc, 4);
        t2 = cyc;
        @(negedge clk);
        cmd_valid = 0;
        finish_rsp("b2b read", 1'b0, 32'h5A5A1234, RESP_OKAY, 0, t2, 3);

        // reset in the middle of a stalled write
        set_dly(6, 6, 0, 0, 0);
        accept_cmd(1'b1, 32'h0C, 32'h77777777, 4'hF, t_acc, waits);
        @(negedge clk);
        check("midrst precondition awvalid", awvalid, 1);
        #2 rst_n = 0;
        #1 check("midrst valids drop", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
        check("midrst cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        set_dly(0, 0, 0, 0, 0);
        #2 rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("midrst after c%0d", i), {cmd_ready, rsp_valid}, 2'b10);
        end
        accept_cmd(1'b0, 32'h0C, 32'h0, 4'h0, t_acc, waits);
        finish_rsp("midrst readback", 1'b0, 32'h0BADF00D, RESP_OKAY, 0, t_acc, 3);

        // randomized transactions against a word-level memory model
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom % 2);
            idx = 16 + int'($urandom % 8);
            addr = 32'(idx * 4);
            data = $urandom;
            strb = 4'($urandom % 16);
            resp = 2'($urandom % 4);
            bp = int'($urandom % 3);
            d_aw = int'($urandom % 4); d_w = int'($urandom % 4); d_b = int'($urandom % 4);
            d_ar = int'($urandom % 4); d_r = int'($urandom % 4);
            set_dly(d_aw, d_w, d_b, d_ar, d_r);
            cfg_bresp = resp; cfg_rresp = resp;
            if (wr) begin
                exp_rd = '0;
                lat = 3 + ((d_aw > d_w) ? d_aw : d_w) + d_b;
                if (resp == RESP_OKAY) ref_mem[idx] = merge(ref_mem[idx], data, strb);
            end else begin
                exp_rd = ref_mem[idx];
                lat = 3 + d_ar + d_r;
            end
            rsp_ready = (bp == 0);
            accept_cmd(wr, addr, data, strb, t_acc, waits);
            finish_rsp($sformatf("rnd%0d", i), wr, exp_rd, resp, bp, t_acc, lat);
            if (wr)
                check($sformatf("rnd%0d aw/w payload", i), {cap_wstrb, cap_awaddr, cap_wdata},
                      {strb, addr, data});
            else
                check($sformatf("rnd%0d ar payload", i), cap_araddr, addr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- AXI4-Lite initiator (manager) that turns a simple single-outstanding command/response interface into AXI4-Lite read and write transactions.
- It is the counterpart of the team's AXI4-Lite slave. Its main uses are driving that slave in system-level benches and acting as the register-access front end for local control logic.
- Exactly one transaction is in flight at a time; there is no pipelining across commands.

Parameters:
- ADDR_WIDTH, 32, address width of the command and AW/AR channels.
- DATA_WIDTH, 32, data width; legal values are 32 and 64. STRB_WIDTH is DATA_WIDTH/8.
- PROT, 3'b000, constant value driven on AWPROT and ARPROT.

Ports:
- i_clock  in  1  single clock for all logic.
- i_areset_n  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  command accepted when high together with i_cmd_valid.
- i_cmd_write  in  1  1 = write, 0 = read.
- i_cmd_addr  in  ADDR_WIDTH  byte address.
- i_cmd_wdata  in  DATA_WIDTH  write data.
- i_cmd_wstrb  in  STRB_WIDTH  write byte strobes.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  response consumer ready.
- o_rsp_write  out  1  response belongs to a write.
- o_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- o_rsp_resp  out  2  BRESP or RRESP as received.
- o_awaddr/o_awprot/o_awvalid/i_awready; o_wdata/o_wstrb/o_wvalid/i_wready; i_bresp/i_bvalid/o_bready; o_araddr/o_arprot/o_arvalid/i_arready; i_rdata/i_rresp/i_rvalid/o_rready: standard AXI4-Lite channels at the widths above.

Behaviour:
- Reset is asynchronous, active-low, and fixed as such.
- While reset is asserted:
  - State is IDLE.
  - All outputs read 0, including all VALID/READY outputs, addresses, data, strobes and the response fields.
  - The exception is o_cmd_ready, which reads 1 so that it is already high when reset deasserts.
- FSM states: IDLE, WR (AW and W outstanding), WR_RESP, RD_ADDR, RD_DATA, RSP.
- o_cmd_ready = (state == IDLE). A command handshake in cycle T registers addr/wdata/wstrb/write.
- Write path:
  - At T+1, state is WR and both o_awvalid and o_wvalid are 1.
  - Each VALID drops the cycle after its own handshake; a flag records completion.
  - AW and W may complete in either order or in the same cycle.
  - Once both are done, go to WR_RESP with o_bready = 1.
  - On i_bvalid & o_bready: capture i_bresp into o_rsp_resp, set o_rsp_write = 1 and o_rsp_rdata = 0, go to RSP.
- Read path:
  - At T+1, state is RD_ADDR and o_arvalid = 1.
  - On handshake go to RD_DATA with o_rready = 1.
  - On i_rvalid & o_rready: capture i_rdata and i_rresp, set o_rsp_write = 0, go to RSP.
- RSP state:
  - o_rsp_valid = 1 and all response fields are held stable until i_rsp_ready.
  - The cycle after the handshake, state returns to IDLE and o_cmd_ready = 1.
- Minimum command-to-response latency with zero-wait slaves:
  - Write: o_rsp_valid at T+3 (AW/W handshake at T+1, B handshake at T+2).
  - Read: o_rsp_valid at T+3.
  - Minimum command-to-command issue interval is 4 cycles with i_rsp_ready tied high.
- AXI rules:
  - A VALID is never withdrawn before its handshake.
  - Payload fields stay stable while VALID is high.
  - o_bready and o_rready are asserted only in their waiting states.
  - AW/AR/W payload outputs hold their last value when VALID is low.
- i_bvalid or i_rvalid arriving in any unexpected state is ignored (no capture). Asserting such a signal is protocol abuse by the slave.
- An SLVERR or DECERR response is passed through unchanged; the block does not retry.
- Reset mid-transaction: all VALIDs fall immediately (asynchronously) and no response is produced for the aborted command.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - The state enum.
  - Response codes RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - The default PROT constant.
- Payload and response holding registers use the codebase's dff_async_rst_n primitive, enabled on the capture handshakes.
- There is no other sub-module; the FSM and handshake flags are local to this block.

Test Plan:
- Zero-wait write: addr 0x10, wdata 0xDEADBEEF, wstrb 0xF -> AW/W handshake at T+1, B handshake at T+2, o_rsp_valid at T+3 with o_rsp_write = 1 and resp 00.
- Skewed write: i_awready delayed 3 cycles, i_wready immediate -> o_wvalid drops after 1 cycle, o_awvalid is held 4 cycles with o_awaddr stable, o_bready rises only after the AW handshake.
- Read error: addr 0x20, slave returns rdata 0x12345678 with rresp 2'b10 after 2 wait cycles -> o_rsp_rdata = 0x12345678, o_rsp_resp = 2'b10, o_rsp_write = 0.
- Response backpressure: i_rsp_ready held low 5 cycles -> o_rsp_valid and all response fields are stable, o_cmd_ready stays 0, and the next command is accepted the cycle after the handshake.
- Back-to-back: write 0x04 then read 0x04 with i_cmd_valid held high -> the second command is accepted only in IDLE, and the read returns the written data from the team's slave.
- Reset mid-write: assert i_areset_n = 0 while o_awvalid = 1 -> all VALIDs are 0 immediately; after release o_cmd_ready = 1 and no stale o_rsp_valid appears.
